// File: rtl/safe_mode_seq_ctrl.sv
// safe_mode_seq_ctrl: reconfigures an N-core cluster between independent,
// DMR and TMR operation and selects the master core. A new configuration is
// applied only after every core acknowledges halt; cores are then released
// and the sequencer waits for them to leave halt. Invalid requests and
// halt/resume timeouts park the sequencer in ERROR until cleared.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_valid_i/cfg_ready_o configuration request handshake
//   cfg_mode_i, cfg_master_i requested mode (0 indep, 1 DMR, 2 TMR) and master
//   halt_req_o, halt_ack_i  per-core halt request / halted acknowledge
//   resume_o                high while waiting for cores to leave halt
//   master_core_o, safe_mode_o, safe_configuration_o  applied configuration
//   busy_o, done_o          sequence in progress / one-cycle completion pulse
//   err_code_o, err_clear_i error code (valid in ERROR only) and its clear
module safe_mode_seq_ctrl #(
    parameter int unsigned NCores        = 3,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned MasterW       = (NCores > 1) ? $clog2(NCores) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [1:0]         cfg_mode_i,
    input  logic [MasterW-1:0] cfg_master_i,
    output logic [NCores-1:0]  halt_req_o,
    input  logic [NCores-1:0]  halt_ack_i,
    output logic               resume_o,
    output logic [MasterW-1:0] master_core_o,
    output logic               safe_mode_o,
    output logic [1:0]         safe_configuration_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         err_code_o,
    input  logic               err_clear_i
);

    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrInvalid = 2'd1;
    localparam logic [1:0] ErrHalt    = 2'd2;
    localparam logic [1:0] ErrResume  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_APPLY,
        S_RESUME,
        S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [MasterW-1:0] master_q, master_d;
    logic [1:0]         pmode_q, pmode_d;
    logic [MasterW-1:0] pmaster_q, pmaster_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;
    logic               done_q, done_d;

    logic accept;
    logic req_invalid;
    logic req_noop;
    logic cnt_last;

    // Request checks; core-count limits fold to constants per instance.
    assign req_invalid = (cfg_mode_i == 2'd3)
                      || (32'(cfg_master_i) >= NCores)
                      || ((cfg_mode_i == 2'd1) && (NCores < 2))
                      || ((cfg_mode_i == 2'd2) && (NCores < 3));
    assign req_noop    = (cfg_mode_i == mode_q) && (cfg_master_i == master_q);
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign cnt_last    = (cnt_q == CntW'(TimeoutCycles - 1));

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            master_q  <= '0;
            pmode_q   <= 2'd0;
            pmaster_q <= '0;
            cnt_q     <= '0;
            err_q     <= ErrNone;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            master_q  <= master_d;
            pmode_q   <= pmode_d;
            pmaster_q <= pmaster_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        master_d  = master_q;
        pmode_d   = pmode_q;
        pmaster_d = pmaster_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_invalid) begin
                        state_d = S_ERROR;
                        err_d   = ErrInvalid;
                    end else if (req_noop) begin
                        done_d = 1'b1;
                    end else begin
                        pmode_d   = cfg_mode_i;
                        pmaster_d = cfg_master_i;
                        cnt_d     = '0;
                        state_d   = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (&halt_ack_i) begin
                    state_d = S_APPLY;
                end else if (cnt_last) begin
                    state_d = S_ERROR;
                    err_d   = ErrHalt;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            S_APPLY: begin
                mode_d   = pmode_q;
                master_d = pmaster_q;
                cnt_d    = '0;
                state_d  = S_RESUME;
            end
            S_RESUME: begin
                if (~|halt_ack_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_last) begin
                    state_d = S_ERROR;
                    err_d   = ErrResume;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            S_ERROR: begin
                if (err_clear_i) begin
                    state_d = S_IDLE;
                    err_d   = ErrNone;
                end
            end
            default: begin
                state_d = S_IDLE;
                err_d   = ErrNone;
            end
        endcase
    end

    // Outputs decoded from registers; ready also masked by reset.
    assign cfg_ready_o          = (state_q == S_IDLE) && !rst_i;
    assign halt_req_o           = {NCores{(state_q == S_HALT) || (state_q == S_APPLY)}};
    assign resume_o             = (state_q == S_RESUME);
    assign busy_o               = (state_q != S_IDLE);
    assign done_o               = done_q;
    assign err_code_o           = err_q;
    assign master_core_o        = master_q;
    assign safe_configuration_o = mode_q;
    assign safe_mode_o          = |mode_q;

endmodule

// File: tb/tb_safe_mode_seq_ctrl.sv
// Bench for safe_mode_seq_ctrl: directed scenarios plus randomized traffic,
// with a behavioural model checked against the DUT every cycle.
module tb_safe_mode_seq_ctrl;

    localparam int unsigned NC = 3;
    localparam int unsigned TO = 16;
    localparam int unsigned MW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [1:0]    cfg_mode_i;
    logic [MW-1:0] cfg_master_i;
    logic [NC-1:0] halt_req_o;
    logic [NC-1:0] halt_ack_i;
    logic          resume_o;
    logic [MW-1:0] master_core_o;
    logic          safe_mode_o;
    logic [1:0]    safe_configuration_o;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    err_code_o;
    logic          err_clear_i;

    safe_mode_seq_ctrl #(.NCores(NC), .TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_mode_i(cfg_mode_i), .cfg_master_i(cfg_master_i),
        .halt_req_o(halt_req_o), .halt_ack_i(halt_ack_i),
        .resume_o(resume_o), .master_core_o(master_core_o),
        .safe_mode_o(safe_mode_o), .safe_configuration_o(safe_configuration_o),
        .busy_o(busy_o), .done_o(done_o),
        .err_code_o(err_code_o), .err_clear_i(err_clear_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Core ack environment: each core raises its ack rise_d cycles after it
    // sees halt_req and drops it fall_d cycles after halt_req falls.
    // Delays >= 200 mean "never".
    int rise_d[NC];
    int fall_d[NC];
    int hi_cnt[NC];
    int lo_cnt[NC];

    initial begin
        halt_ack_i = '0;
        for (int i = 0; i < NC; i++) begin
            hi_cnt[i] = 0;
            lo_cnt[i] = 200;
        end
        forever begin
            @(posedge clk_i);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (halt_req_o[i] === 1'b1) begin
                    lo_cnt[i] = 0;
                    if (hi_cnt[i] < 200) hi_cnt[i]++;
                    if (hi_cnt[i] > rise_d[i]) halt_ack_i[i] = 1'b1;
                end else begin
                    hi_cnt[i] = 0;
                    if (lo_cnt[i] < 200) lo_cnt[i]++;
                    if (lo_cnt[i] > fall_d[i]) halt_ack_i[i] = 1'b0;
                end
            end
        end
    end

    task automatic set_delays(input int r, input int f);
        for (int i = 0; i < NC; i++) begin
            rise_d[i] = r;
            fall_d[i] = f;
        end
    endtask

    // Behavioural model: phase 0 idle, 1 halting, 2 applying, 3 resuming, 4 error.
    int         m_phase;
    int         m_wait;
    logic [1:0] m_mode, p_mode, m_err;
    logic [1:0] m_master, p_master;
    logic       m_done;
    bit         cmp_en = 1'b0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_phase  <= 0;
            m_wait   <= 0;
            m_mode   <= 2'd0;
            m_master <= 2'd0;
            m_err    <= 2'd0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            case (m_phase)
                0: if (cfg_valid_i) begin
                    if (cfg_mode_i == 2'd3 || int'(cfg_master_i) >= NC
                        || (cfg_mode_i == 2'd1 && NC < 2) || (cfg_mode_i == 2'd2 && NC < 3)) begin
                        m_phase <= 4;
                        m_err   <= 2'd1;
                    end else if (cfg_mode_i == m_mode && cfg_master_i == m_master) begin
                        m_done <= 1'b1;
                    end else begin
                        p_mode   <= cfg_mode_i;
                        p_master <= cfg_master_i;
                        m_wait   <= 0;
                        m_phase  <= 1;
                    end
                end
                1: if (&halt_ack_i) m_phase <= 2;
                   else if (m_wait == TO - 1) begin m_phase <= 4; m_err <= 2'd2; end
                   else m_wait <= m_wait + 1;
                2: begin
                    m_mode   <= p_mode;
                    m_master <= p_master;
                    m_wait   <= 0;
                    m_phase  <= 3;
                end
                3: if (~|halt_ack_i) begin m_phase <= 0; m_done <= 1'b1; end
                   else if (m_wait == TO - 1) begin m_phase <= 4; m_err <= 2'd3; end
                   else m_wait <= m_wait + 1;
                default: if (err_clear_i) begin m_phase <= 0; m_err <= 2'd0; end
            endcase
        end
    end

    // Every-cycle comparison of the full output bundle.
    always @(negedge clk_i) begin
        if (cmp_en) begin
            logic [13:0] act, exp;
            act = {halt_req_o, resume_o, busy_o, cfg_ready_o, master_core_o,
                   safe_configuration_o, safe_mode_o, done_o, err_code_o};
            exp = {(m_phase == 1 || m_phase == 2) ? 3'b111 : 3'b000,
                   m_phase == 3, m_phase != 0, (m_phase == 0) && !rst_i,
                   m_master, m_mode, m_mode != 2'd0, m_done,
                   (m_phase == 4) ? m_err : 2'd0};
            check("model_outputs", 32'(act), 32'(exp));
        end
    end

    task automatic req(input logic [1:0] mode, input logic [1:0] master);
        cfg_valid_i  = 1'b1;
        cfg_mode_i   = mode;
        cfg_master_i = master;
        cyc();
        cfg_valid_i  = 1'b0;
    endtask

    // Waits for done_o; n is negedges elapsed, busy_n counts busy cycles before it.
    task automatic wait_done(input int bound, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (n < bound) begin
            @(negedge clk_i);
            n++;
            if (done_o === 1'b1) break;
            if (busy_o === 1'b1) busy_n++;
        end
        check("done_seen", 32'(done_o), 32'd1);
    endtask

    task automatic clear_err();
        cyc();
        err_clear_i = 1'b1;
        cyc();
        err_clear_i = 1'b0;
    endtask

    task automatic invalid_req(input logic [1:0] mode, input logic [1:0] master);
        req(mode, master);
        @(negedge clk_i);
        check("inv_err", 32'(err_code_o), 32'd1);
        check("inv_ready", 32'(cfg_ready_o), 32'd0);
        check("inv_cfg", 32'({safe_configuration_o, master_core_o}), 32'({2'd1, 2'd0}));
        cyc();
        @(negedge clk_i);
        check("inv_err_hold", 32'(err_code_o), 32'd1);
        clear_err();
        @(negedge clk_i);
        check("inv_cleared", 32'({err_code_o, cfg_ready_o, busy_o}), 32'({2'd0, 1'b1, 1'b0}));
        cyc();
    endtask

    int n, bn, hc, rc;

    initial begin
        rst_i = 1'b1;
        cfg_valid_i = 1'b0;
        cfg_mode_i = 2'd0;
        cfg_master_i = '0;
        err_clear_i = 1'b0;
        set_delays(3, 2);
        cyc();
        cmp_en = 1'b1;
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_ready", 32'(cfg_ready_o), 32'd1);
        check("reset_outs", 32'({busy_o, done_o, err_code_o, master_core_o, safe_configuration_o, safe_mode_o, halt_req_o, resume_o}), 32'd0);
        cyc();

        // Full reconfiguration to TMR, master 1.
        req(2'd2, 2'd1);
        wait_done(100, n, bn);
        check("seq_busy_span", 32'(bn), 32'(n - 1));
        check("seq_master", 32'(master_core_o), 32'd1);
        check("seq_mode", 32'(safe_configuration_o), 32'd2);
        check("seq_safe", 32'(safe_mode_o), 32'd1);
        cyc();
        @(negedge clk_i);
        check("seq_done_once", 32'(done_o), 32'd0);
        cyc();

        // Same request again is a no-op.
        req(2'd2, 2'd1);
        @(negedge clk_i);
        check("noop_done", 32'({done_o, busy_o, halt_req_o}), 32'({1'b1, 1'b0, 3'b000}));
        cyc();

        // Minimum latency with immediate acks.
        set_delays(0, 0);
        req(2'd1, 2'd0);
        wait_done(20, n, bn);
        check("min_latency", 32'(n), 32'd4);
        check("min_cfg", 32'({safe_configuration_o, master_core_o}), 32'({2'd1, 2'd0}));
        cyc();

        // Invalid requests.
        invalid_req(2'd3, 2'd0);
        invalid_req(2'd0, 2'd3);

        // Halt timeout: core 2 never acks.
        set_delays(1, 1);
        rise_d[2] = 255;
        req(2'd1, 2'd2);
        hc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (err_code_o !== 2'd0) break;
            if (halt_req_o !== '0) hc++;
        end
        check("halt_cycles", 32'(hc), 32'(TO));
        check("halt_to_err", 32'({err_code_o, halt_req_o}), 32'({2'd2, 3'b000}));
        check("halt_to_cfg", 32'({safe_configuration_o, master_core_o}), 32'({2'd1, 2'd0}));
        rise_d[2] = 2;
        cyc();
        err_clear_i  = 1'b1;
        cfg_valid_i  = 1'b1;
        cfg_mode_i   = 2'd2;
        cfg_master_i = 2'd2;
        @(negedge clk_i);
        check("clr_ready_low", 32'(cfg_ready_o), 32'd0);
        cyc();
        err_clear_i = 1'b0;
        @(negedge clk_i);
        check("clr_not_taken", 32'({busy_o, cfg_ready_o}), 32'({1'b0, 1'b1}));
        cyc();
        cfg_valid_i = 1'b0;
        @(negedge clk_i);
        check("clr_then_accept", 32'(busy_o), 32'd1);
        wait_done(100, n, bn);
        check("clr_cfg", 32'({safe_configuration_o, master_core_o}), 32'({2'd2, 2'd2}));
        cyc();

        // Resume timeout: acks never drop.
        set_delays(1, 255);
        req(2'd0, 2'd1);
        rc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (err_code_o !== 2'd0) break;
            if (resume_o === 1'b1) rc++;
        end
        check("resume_cycles", 32'(rc), 32'(TO));
        check("resume_to_err", 32'({err_code_o, resume_o}), 32'({2'd3, 1'b0}));
        check("resume_to_cfg", 32'({safe_configuration_o, master_core_o, safe_mode_o}), 32'({2'd0, 2'd1, 1'b0}));
        set_delays(5, 1);
        clear_err();
        cyc();

        // Reset during HALT.
        req(2'd2, 2'd0);
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_halt", 32'({busy_o, done_o, halt_req_o, master_core_o, safe_configuration_o}), 32'd0);
        cyc();

        // Reset during APPLY (config currently 0/0 after reset).
        set_delays(0, 0);
        req(2'd1, 2'd1);
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_apply", 32'({busy_o, done_o, halt_req_o, master_core_o, safe_configuration_o}), 32'd0);
        cyc();
        @(negedge clk_i);
        check("rst_apply_nodone", 32'(done_o), 32'd0);
        cyc();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c % 25 == 0) begin
                for (int i = 0; i < NC; i++) begin
                    rise_d[i] = ($urandom % 12 == 0) ? 255 : int'($urandom % 6);
                    fall_d[i] = ($urandom % 12 == 0) ? 255 : int'($urandom % 6);
                end
            end
            cfg_valid_i  = ($urandom % 3 == 0);
            cfg_mode_i   = 2'($urandom % 4);
            cfg_master_i = 2'($urandom % 4);
            err_clear_i  = ($urandom % 6 == 0);
            rst_i        = ($urandom % 300 == 0);
            cyc();
        end
        rst_i = 1'b0;
        cfg_valid_i = 1'b0;
        err_clear_i = 1'b0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
